dip_config_ctrl: RTL and testbench
==================================

# dip_config_ctrl

Sequences DIP-switch configuration from the HPS ioctl download channel into the Computer Space game core. Writes for the DIP index go to a shadow register file. When the download ends, the new settings are committed atomically at the next game vertical sync, and the core gets a timed reset so it restarts under the new settings. The block sits between `hps_io` and `computer_space_top` in the `clk_sys` domain and replaces the bare DIP register array in the top level.

## Interface
Parameters:
- `NUM_BYTES`, 8: number of DIP bytes held; legal range 1..8.
- `DIP_INDEX`, 254: ioctl index that carries DIP data.
- `RESET_HOLD`, 16: cycles `game_reset` stays high after a commit; must be ≥1.
- `VS_TIMEOUT`, 1048576: cycles to wait for vsync before committing anyway.

Ports:
- `clk_sys` in 1: system clock (50 MHz); the only clock.
- `reset` in 1: synchronous, active-high. Driven only by power-on `RESET`, never by the user reset.
- `ioctl_download` in 1: high while a download is in progress.
- `ioctl_wr` in 1: byte write strobe, one cycle wide.
- `ioctl_addr` in 27: byte address.
- `ioctl_dout` in 8: write data.
- `ioctl_index` in 16: download index.
- `vsync` in 1: game vsync from the `clk_5m` domain; asynchronous to `clk_sys`.
- `dip_out` out `NUM_BYTES*8`: active configuration; byte n is at [8n+7:8n].
- `cfg_valid` out 1: at least one commit has happened since reset.
- `game_reset` out 1: reset request to the core; ORed into the core reset at top level.
- `busy` out 1: high when state ≠ IDLE or `game_reset` is high.

## Operation
- Shadow write:
  - Condition: `ioctl_wr && ioctl_index==DIP_INDEX && ioctl_addr < NUM_BYTES`. Action: `shadow[addr] <= ioctl_dout`.
  - A write is accepted in any state, including during WAIT_VS.
  - Addresses ≥ `NUM_BYTES` are ignored.
  - Bytes not written keep their previous shadow value, so partial downloads are legal.
- `dl_rise` / `dl_fall`: registered edges of `ioctl_download`, qualified by `ioctl_index==DIP_INDEX`. The index is sampled on the rising edge and held for the whole download.
- FSM states are IDLE, LOAD and WAIT_VS:
  - **IDLE**: `dl_rise` → LOAD.
  - **LOAD**: `dl_fall` → WAIT_VS if `shadow != dip_out || !cfg_valid`; otherwise → IDLE with no commit and no reset.
  - **WAIT_VS**:
    - On `vs_rise` or timeout counter == `VS_TIMEOUT-1`, commit and go to IDLE.
    - On `dl_rise`, go to LOAD and abandon the pending commit. `dl_rise` wins over a simultaneous `vs_rise`.
- Commit, in one cycle:
  - `dip_out <= shadow`
  - `cfg_valid <= 1`
  - hold counter loaded to `RESET_HOLD`
- Hold counter:
  - Decrements to 0, independently of the FSM.
  - `game_reset = (hold counter != 0)`.
  - A new commit while the counter is nonzero reloads it to `RESET_HOLD`.
- Timeout counter: cleared on entry to WAIT_VS and counts up every cycle in WAIT_VS. It exists so a commit still happens when the core produces no video (held in reset, pll unlocked).
- `dl_rise` while in LOAD is ignored, since a download is already in progress.
- Reset clears the FSM to IDLE and zeroes both counters, the shadow array, `dip_out`, `cfg_valid` and `game_reset`. Reset mid-download discards the download; later writes still update the shadow, but no commit occurs until a fresh `dl_rise`.

## Timing
- Shadow write is visible in `shadow` on the clock edge after `ioctl_wr`.
- `vsync` passes through a 2-flop synchronizer and an edge register.
  - `vs_rise` goes high on the 3rd `clk_sys` edge after `vsync` rises, stable enough to be sampled.
  - `dip_out` and `game_reset` change on the following edge, giving 4 cycles from vsync to commit.
- `dl_fall` is 1 cycle after `ioctl_download` falls. WAIT_VS is entered on the edge after `dl_fall`.
- A write in the same cycle that `ioctl_download` falls is accepted and included in the comparison.
- `game_reset` is high for exactly `RESET_HOLD` consecutive cycles, starting the cycle `dip_out` changes.
- Reset values: `dip_out`=0, `cfg_valid`=0, `game_reset`=0, `busy`=0.

## Structure
- Package `comspc_cfg_pkg` holds:
  - the state enum `cfg_state_t` (IDLE, LOAD, WAIT_VS)
  - the constant `DIP_INDEX_DEFAULT=254`
  - DIP bit-position constants: `SW_2PLAYPERCOIN`=bit 0 of byte 0, `SW_REPLAY`=bit 1 of byte 0
- Sub-module `sync_edge_det`: 2-flop synchronizer plus rising-edge pulse. Instantiated once, for `vsync`.

## Test plan
- First load: after reset, download index 254 writing byte0=0x03. Toggle `vsync` 40 cycles after the download ends. Expect `dip_out[7:0]`=0x03 and `cfg_valid`=1 four cycles after the vsync edge, with `game_reset` high for 16 cycles.
- No change: repeat the same download. Expect FSM back in IDLE 2 cycles after `ioctl_download` falls, `game_reset` never high, and `dip_out` unchanged.
- Ignored writes: index 0 data, and index 254 with addr=8. Expect shadow unchanged and no state change. Partial download of byte1=0x5A commits as 0x5A03 with byte0 retained.
- Timeout: hold `vsync` low with `VS_TIMEOUT`=64. Expect the commit exactly 64 cycles after WAIT_VS entry.
- Restart: a new `dl_rise` in WAIT_VS on the same cycle as `vs_rise`. Expect no commit and state LOAD. The second download's data commits on the next vsync.
- Reset mid-operation: assert `reset` during WAIT_VS while `game_reset` is high. Expect all outputs 0 the next cycle and no commit on subsequent vsync.

Source files
------------

// File: rtl/comspc_cfg_pkg.sv
// Shared types and constants for the Computer Space DIP configuration path.
package comspc_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_VS = 2'd2
  } cfg_state_t;

  // ioctl index the HPS uses for DIP-switch downloads
  localparam int DIP_INDEX_DEFAULT = 254;

  // DIP bit positions inside byte 0 of dip_out
  localparam int SW_2PLAYPERCOIN = 0;
  localparam int SW_REPLAY       = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge pulse one clk cycle wide.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q, rise_q;

  // Metastability chain, then edge detect on the settled copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/dip_config_ctrl.sv
// DIP-switch configuration sequencer: ioctl writes land in a shadow copy,
// which is committed to the game core atomically at the next vsync (or after
// a timeout), followed by a fixed-length core reset pulse.
module dip_config_ctrl
  import comspc_cfg_pkg::*;
#(
  parameter int NUM_BYTES  = 8,
  parameter int DIP_INDEX  = DIP_INDEX_DEFAULT,
  parameter int RESET_HOLD = 16,
  parameter int VS_TIMEOUT = 1048576
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [26:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [15:0]            ioctl_index,
  input  logic                   vsync,
  output logic [NUM_BYTES*8-1:0] dip_out,
  output logic                   cfg_valid,
  output logic                   game_reset,
  output logic                   busy
);

  localparam int DIP_W  = NUM_BYTES * 8;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int TO_W   = $clog2(VS_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(VS_TIMEOUT - 1);

  cfg_state_t        state_q;
  logic [DIP_W-1:0]  shadow_q;
  logic [DIP_W-1:0]  dip_q;
  logic              cfg_valid_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q;
  logic              dl_prev_q, dl_idx_q, dl_rise_q, dl_fall_q;
  logic              vs_rise;
  logic              idx_match, commit;

  assign idx_match = (ioctl_index == 16'(DIP_INDEX));

  // A rising dl_rise takes priority over vsync/timeout: the pending commit is dropped.
  assign commit = (state_q == WAIT_VS) && !dl_rise_q &&
                  (vs_rise || (to_q == TO_LAST));

  sync_edge_det u_vs_sync (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .d_i    (vsync),
    .rise_o (vs_rise)
  );

  // Shadow register file; out-of-range addresses match no byte and are dropped.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (ioctl_wr && idx_match) begin
      for (int n = 0; n < NUM_BYTES; n++) begin
        if (ioctl_addr == 27'(n)) shadow_q[n*8 +: 8] <= ioctl_dout;
      end
    end
  end

  // Download edge detection; the index is latched at the start of a download.
  // dl_prev_q resets high so a download already running at reset is never seen as starting.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev_q <= 1'b1;
      dl_idx_q  <= 1'b0;
      dl_rise_q <= 1'b0;
      dl_fall_q <= 1'b0;
    end else begin
      dl_prev_q <= ioctl_download;
      if (ioctl_download && !dl_prev_q) dl_idx_q <= idx_match;
      dl_rise_q <= ioctl_download && !dl_prev_q && idx_match;
      dl_fall_q <= !ioctl_download && dl_prev_q && dl_idx_q;
    end
  end

  // Control FSM with the committed configuration and the vsync timeout counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      dip_q       <= '0;
      cfg_valid_q <= 1'b0;
      to_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dl_rise_q) state_q <= LOAD;
        end
        LOAD: begin
          if (dl_fall_q) begin
            if ((shadow_q != dip_q) || !cfg_valid_q) begin
              state_q <= WAIT_VS;
              to_q    <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_VS: begin
          to_q <= to_q + 1'b1;
          if (dl_rise_q) begin
            state_q <= LOAD;
          end else if (commit) begin
            state_q     <= IDLE;
            dip_q       <= shadow_q;
            cfg_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset-hold countdown: reloaded on every commit, otherwise runs down to zero.
  always_comb begin
    hold_d = hold_q;
    if (commit)           hold_d = HOLD_LOAD;
    else if (hold_q != 0) hold_d = hold_q - 1'b1;
  end

  // Hold counter register.
  always_ff @(posedge clk_sys) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign dip_out    = dip_q;
  assign cfg_valid  = cfg_valid_q;
  assign game_reset = (hold_q != 0);
  assign busy       = (state_q != IDLE) || (hold_q != 0);

endmodule

// File: tb/tb_dip_config_ctrl.sv
// Directed bench for dip_config_ctrl with a commit scoreboard.
module tb_dip_config_ctrl;
  import comspc_cfg_pkg::*;

  localparam int NB   = 8;
  localparam int HOLD = 16;
  localparam int VST  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] ioctl_index = '0;
  logic        vsync = 1'b0;
  logic [NB*8-1:0] dip_out;
  logic        cfg_valid, game_reset, busy;

  int cyc = 0;
  int ntests = 0;
  int nfail = 0;

  // Monitor-side records (written only by the monitor)
  logic [63:0] obs_dip [32];
  int          obs_cyc [32];
  int          obs_wr = 0;
  int          len_arr [32];
  int          len_wr = 0;
  logic        gr_prev = 1'b0;
  int          run = 0;

  // Main-side scoreboard
  typedef struct {
    logic [63:0] dip;
    int          cyc;
  } ev_t;
  ev_t exp_q [$];
  int  obs_rd = 0;
  int  len_rd = 0;
  int  f_cyc;

  dip_config_ctrl #(
    .NUM_BYTES  (NB),
    .DIP_INDEX  (254),
    .RESET_HOLD (HOLD),
    .VS_TIMEOUT (VST)
  ) dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .vsync          (vsync),
    .dip_out        (dip_out),
    .cfg_valid      (cfg_valid),
    .game_reset     (game_reset),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records each commit (game_reset rising) and each completed hold pulse length.
  always @(negedge clk) begin
    if (reset) begin
      gr_prev <= 1'b0;
      run     <= 0;
    end else begin
      gr_prev <= game_reset;
      if (game_reset === 1'b1 && !gr_prev && obs_wr < 32) begin
        obs_dip[obs_wr] <= 64'(dip_out);
        obs_cyc[obs_wr] <= cyc;
        obs_wr          <= obs_wr + 1;
      end
      if (game_reset === 1'b1) begin
        run <= run + 1;
      end else if (gr_prev) begin
        if (len_wr < 32) begin
          len_arr[len_wr] <= run;
          len_wr          <= len_wr + 1;
        end
        run <= 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dl_start(input logic [15:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic dl_write(input int addr, input logic [7:0] data);
    ioctl_wr   = 1'b1;
    ioctl_addr = 27'(addr);
    ioctl_dout = data;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
  endtask

  task automatic expect_commit(input string tag, input int budget);
    ev_t e;
    int  b = budget;
    while (obs_wr == obs_rd && b > 0) begin
      step();
      b--;
    end
    chk({tag, "_seen"}, 64'(obs_wr - obs_rd), 64'd1);
    if (obs_wr != obs_rd && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_dip"}, obs_dip[obs_rd], e.dip);
      chk({tag, "_cycle"}, 64'(obs_cyc[obs_rd]), 64'(e.cyc));
      obs_rd++;
    end
  endtask

  task automatic expect_len(input string tag);
    int b = 40;
    while (len_wr == len_rd && b > 0) begin
      step();
      b--;
    end
    chk({tag, "_seen"}, 64'(len_wr - len_rd), 64'd1);
    if (len_wr != len_rd) begin
      chk({tag, "_len"}, 64'(len_arr[len_rd]), 64'(HOLD));
      len_rd++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_dip", 64'(dip_out), 64'd0);
    chk("rst_valid", 64'(cfg_valid), 64'd0);
    chk("rst_greset", 64'(game_reset), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // First load: byte0 = 0x03, vsync 40 cycles after the download ends
    dl_start(16'd254);
    dl_write(0, 8'h03);
    dl_end();
    repeat (40) step();
    vsync = 1'b1;
    exp_q.push_back('{64'h03, cyc + 4});
    repeat (3) step();
    chk("first_dip_before", 64'(dip_out), 64'd0);
    step();
    chk("first_dip", 64'(dip_out), 64'h03);
    chk("first_valid", 64'(cfg_valid), 64'd1);
    chk("first_greset", 64'(game_reset), 64'd1);
    vsync = 1'b0;
    expect_commit("first", 20);
    expect_len("first_hold");

    // No change: same data returns to IDLE two cycles after the fall, no reset
    dl_start(16'd254);
    dl_write(0, 8'h03);
    dl_end();
    step();
    chk("nochg_load", 64'(busy), 64'd1);
    step();
    chk("nochg_idle", 64'(busy), 64'd0);
    chk("nochg_state", 64'(dut.state_q), 64'(IDLE));
    repeat (80) step();
    chk("nochg_nocommit", 64'(obs_wr - obs_rd), 64'd0);
    chk("nochg_dip", 64'(dip_out), 64'h03);

    // Ignored writes: foreign index, then DIP index at an out-of-range address
    dl_start(16'd0);
    dl_write(0, 8'hFF);
    chk("idx0_idle", 64'(busy), 64'd0);
    dl_end();
    repeat (2) step();
    dl_start(16'd254);
    dl_write(NB, 8'hEE);
    dl_end();
    repeat (2) step();
    chk("addr8_idle", 64'(busy), 64'd0);
    repeat (80) step();
    chk("ignored_nocommit", 64'(obs_wr - obs_rd), 64'd0);

    // Partial download: only byte1 written, byte0 retained
    dl_start(16'd254);
    dl_write(1, 8'h5A);
    dl_end();
    repeat (10) step();
    vsync = 1'b1;
    exp_q.push_back('{64'h5A03, cyc + 4});
    repeat (2) step();
    vsync = 1'b0;
    expect_commit("partial", 20);
    expect_len("partial_hold");

    // Timeout: no vsync, commit VS_TIMEOUT cycles after WAIT_VS entry
    dl_start(16'd254);
    dl_write(2, 8'h11);
    dl_end();
    f_cyc = cyc;
    exp_q.push_back('{64'h115A03, f_cyc + 2 + VST});
    repeat (2) step();
    chk("to_state", 64'(dut.state_q), 64'(WAIT_VS));
    expect_commit("timeout", 100);
    expect_len("timeout_hold");

    // Restart: dl_rise lands in WAIT_VS on the same cycle as vs_rise
    dl_start(16'd254);
    dl_write(3, 8'h22);
    dl_end();
    repeat (5) step();
    vsync = 1'b1;
    repeat (2) step();
    dl_start(16'd254);
    step();
    chk("restart_state", 64'(dut.state_q), 64'(LOAD));
    chk("restart_busy", 64'(busy), 64'd1);
    vsync = 1'b0;
    dl_write(3, 8'h33);
    dl_end();
    repeat (3) step();
    chk("restart_nocommit", 64'(obs_wr - obs_rd), 64'd0);
    chk("restart_dip_kept", 64'(dip_out), 64'h115A03);
    repeat (5) step();
    vsync = 1'b1;
    exp_q.push_back('{64'h33115A03, cyc + 4});
    repeat (2) step();
    vsync = 1'b0;
    expect_commit("restart", 20);
    expect_len("restart_hold");

    // Reset while in WAIT_VS with game_reset still high
    dl_start(16'd254);
    dl_write(4, 8'h44);
    dl_end();
    repeat (5) step();
    vsync = 1'b1;
    exp_q.push_back('{64'h0000_0044_3311_5A03, cyc + 4});
    repeat (2) step();
    vsync = 1'b0;
    repeat (2) step();
    chk("rstcase_hold", 64'(game_reset), 64'd1);
    dl_start(16'd254);
    dl_write(5, 8'h55);
    dl_end();
    repeat (2) step();
    chk("rstcase_state", 64'(dut.state_q), 64'(WAIT_VS));
    chk("rstcase_greset_pre", 64'(game_reset), 64'd1);
    reset = 1'b1;
    step();
    chk("rstcase_dip", 64'(dip_out), 64'd0);
    chk("rstcase_valid", 64'(cfg_valid), 64'd0);
    chk("rstcase_greset", 64'(game_reset), 64'd0);
    chk("rstcase_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();
    expect_commit("rstcase_commit", 5);
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (30) step();
    chk("rstcase_nocommit", 64'(obs_wr - obs_rd), 64'd0);
    chk("rstcase_dip_after", 64'(dip_out), 64'd0);
    chk("rstcase_valid_after", 64'(cfg_valid), 64'd0);
    chk("stray_hold_pulses", 64'(len_wr - len_rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
